// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   - Bus widths of the EX->MEM payload, MEM->WB payload and forwarding bus.
//   - Load-op codes carried in the EX payload (bit 2 selects zero-extension).
//   - Packed payload layouts, MSB first, matching the bus concatenation order.
package mem_stage_pkg;

  localparam int TO_MEM_DATA_W  = 74;
  localparam int TO_WB_DATA_W   = 70;
  localparam int FORWARD_DATA_W = 37;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b101,
    LD_HU = 3'b110
  } ld_op_e;

  // {pc, dest, alu_result, gr_we, res_from_mem, ld_op}
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        gr_we;
    logic        res_from_mem;
    logic [2:0]  ld_op;
  } mem_payload_t;

  // {pc, dest, final_result, gr_we}
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic        gr_we;
  } wb_payload_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   rdata     in   DATA_W   word returned by the data SRAM
//   addr      in   2        low address bits: byte select [1:0], half select [1]
//   ld_op     in   LD_OP_W  W / B / H / BU / HU; reserved codes behave as W
//   load_data out  DATA_W   extracted and sign/zero-extended value
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LD_OP_W = 3
) (
  input  logic [DATA_W-1:0]  rdata,
  input  logic [1:0]         addr,
  input  logic [LD_OP_W-1:0] ld_op,
  output logic [DATA_W-1:0]  load_data
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic zext);
    logic signed [7:0]        sb;
    logic signed [DATA_W-1:0] sx;
    sb = b;
    sx = DATA_W'(sb);
    if (zext) return {{(DATA_W-8){1'b0}}, b};
    else      return sx;
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic zext);
    logic signed [15:0]       sh;
    logic signed [DATA_W-1:0] sx;
    sh = h;
    sx = DATA_W'(sh);
    if (zext) return {{(DATA_W-16){1'b0}}, h};
    else      return sx;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        zext;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  assign zext     = ld_op[2];

  always_comb begin
    load_data = rdata;
    case (ld_op)
      LD_B, LD_BU: load_data = ext_byte(byte_sel, zext);
      LD_H, LD_HU: load_data = ext_half(half_sel, zext);
      default:     load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage in-order pipeline (EX -> MEM -> WB).
// Holds one instruction, aligns/extends load data from the synchronous data
// SRAM (read issued in EX, data arrives while the instruction sits in MEM),
// and produces the WB payload and the forwarding bus.
// Optional feature macro: MEM_RDATA_BUF_EN -- captures SRAM read data when WB
// stalls a load, since the SRAM only presents it for one cycle. Without it,
// WB must never stall.
// Ports:
//   clk              in   1    clock
//   reset            in   1    synchronous, active-high
//   to_MEM_data      in   74   {pc, dest, alu_result, gr_we, res_from_mem, ld_op}
//   EX_to_MEM_valid  in   1    EX presents a valid instruction
//   MEM_allow_in     out  1    MEM accepts from EX this cycle
//   data_sram_rdata  in   32   SRAM read data for the instruction in MEM
//   to_WB_data       out  70   {pc, dest, final_result, gr_we}
//   MEM_to_WB_valid  out  1    MEM presents a valid instruction to WB
//   WB_allow_in      in   1    WB accepts this cycle
//   MEM_forward      out  37   {dest (0 when no write), final_result}
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LD_OP_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [TO_MEM_DATA_W-1:0]  to_MEM_data,
  input  logic                      EX_to_MEM_valid,
  output logic                      MEM_allow_in,
  input  logic [DATA_W-1:0]         data_sram_rdata,
  output logic [TO_WB_DATA_W-1:0]   to_WB_data,
  output logic                      MEM_to_WB_valid,
  input  logic                      WB_allow_in,
  output logic [FORWARD_DATA_W-1:0] MEM_forward
);

  logic          vld_p1;
  mem_payload_t  payload_p1;
  logic          mem_ready_go;
  logic [DATA_W-1:0] load_src;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;
  wb_payload_t   wb_payload;

  assign mem_ready_go    = 1'b1;
  assign MEM_allow_in    = ~vld_p1 | (mem_ready_go & WB_allow_in);
  assign MEM_to_WB_valid = vld_p1 & mem_ready_go;

  // ---- EX -> MEM pipeline register ----
  always_ff @(posedge clk) begin
    if (reset)             vld_p1 <= 1'b0;
    else if (MEM_allow_in) vld_p1 <= EX_to_MEM_valid;
  end

  always_ff @(posedge clk) begin
    if (EX_to_MEM_valid & MEM_allow_in) payload_p1 <= mem_payload_t'(to_MEM_data);
  end

`ifdef MEM_RDATA_BUF_EN
  logic              buf_vld_p1;
  logic [DATA_W-1:0] rdata_buf_p1;
  logic              buf_capture;

  // Grab the one-cycle SRAM word the first cycle a load is stalled by WB.
  assign buf_capture = vld_p1 & payload_p1.res_from_mem & ~buf_vld_p1 & ~WB_allow_in;

  always_ff @(posedge clk) begin
    if (reset)                      buf_vld_p1 <= 1'b0;
    else if (vld_p1 & WB_allow_in)  buf_vld_p1 <= 1'b0;
    else if (buf_capture)           buf_vld_p1 <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (buf_capture) rdata_buf_p1 <= data_sram_rdata;
  end

  assign load_src = buf_vld_p1 ? rdata_buf_p1 : data_sram_rdata;
`else
  assign load_src = data_sram_rdata;
`endif

  // ---- MEM result / WB payload ----
  mem_load_align #(
    .DATA_W  (DATA_W),
    .LD_OP_W (LD_OP_W)
  ) u_load_align (
    .rdata     (load_src),
    .addr      (payload_p1.alu_result[1:0]),
    .ld_op     (payload_p1.ld_op),
    .load_data (load_data)
  );

  assign final_result = payload_p1.res_from_mem ? load_data : payload_p1.alu_result;

  assign wb_payload.pc           = payload_p1.pc;
  assign wb_payload.dest         = payload_p1.dest;
  assign wb_payload.final_result = final_result;
  assign wb_payload.gr_we        = payload_p1.gr_we;
  assign to_WB_data              = wb_payload;

  // Dest is zeroed when nothing will be written so ID never matches a stale register.
  assign MEM_forward = {payload_p1.dest & {5{vld_p1 & payload_p1.gr_we}}, final_result};

endmodule
